// File: rtl/data_table_upsert.sv
// Hash-table upsert engine: walks one bucket chain in data RAM and then
// inserts, updates or rejects according to the task mode. It reports the
// previous value on a key match and the number of entries it read.
module data_table_upsert #(
  parameter int KEY_WIDTH     = 32,
  parameter int VALUE_WIDTH   = 16,
  parameter int A_WIDTH       = 8,
  parameter int BUCKET_WIDTH  = 8,
  parameter int RAM_LATENCY   = 2,
  parameter int MAX_CHAIN_LEN = 16,
  localparam int CW           = $clog2(MAX_CHAIN_LEN + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [KEY_WIDTH-1:0]    task_key_i,
  input  logic [VALUE_WIDTH-1:0]  task_value_i,
  input  logic [1:0]              task_mode_i,
  input  logic [BUCKET_WIDTH-1:0] task_bucket_i,
  input  logic [A_WIDTH-1:0]      task_head_ptr_i,
  input  logic                    task_head_ptr_val_i,
  input  logic                    task_valid_i,
  output logic                    task_ready_o,
  output logic                    rd_en_o,
  output logic [A_WIDTH-1:0]      rd_addr_o,
  input  logic [KEY_WIDTH-1:0]    rd_key_i,
  input  logic [VALUE_WIDTH-1:0]  rd_value_i,
  input  logic [A_WIDTH-1:0]      rd_next_ptr_i,
  input  logic                    rd_next_ptr_val_i,
  output logic                    wr_en_o,
  output logic [A_WIDTH-1:0]      wr_addr_o,
  output logic [KEY_WIDTH-1:0]    wr_key_o,
  output logic [VALUE_WIDTH-1:0]  wr_value_o,
  output logic [A_WIDTH-1:0]      wr_next_ptr_o,
  output logic                    wr_next_ptr_val_o,
  input  logic [A_WIDTH-1:0]      empty_addr_i,
  input  logic                    empty_addr_val_i,
  output logic                    empty_addr_rd_ack_o,
  output logic                    head_wr_en_o,
  output logic [BUCKET_WIDTH-1:0] head_wr_addr_o,
  output logic [A_WIDTH-1:0]      head_wr_ptr_o,
  output logic                    head_wr_ptr_val_o,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [2:0]              res_code_o,
  output logic [KEY_WIDTH-1:0]    res_key_o,
  output logic [BUCKET_WIDTH-1:0] res_bucket_o,
  output logic [VALUE_WIDTH-1:0]  res_old_value_o,
  output logic [CW-1:0]           res_chain_len_o
);

  localparam int LW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

  localparam logic [2:0] RC_OK_NEW      = 3'd0;
  localparam logic [2:0] RC_OK_UPDATED  = 3'd1;
  localparam logic [2:0] RC_FULL        = 3'd2;
  localparam logic [2:0] RC_KEY_EXISTS  = 3'd3;
  localparam logic [2:0] RC_NOT_FOUND   = 3'd4;
  localparam logic [2:0] RC_CHAIN_LIMIT = 3'd5;

  localparam logic [1:0] MODE_INSERT_ONLY = 2'd1;
  localparam logic [1:0] MODE_UPDATE_ONLY = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_NEW, S_WR_LINK, S_WR_UPD, S_RESULT
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              res_code_q, res_code_d;
  logic [KEY_WIDTH-1:0]    key_q;
  logic [VALUE_WIDTH-1:0]  value_q;
  logic [1:0]              mode_q;
  logic [BUCKET_WIDTH-1:0] bucket_q;
  logic                    head_val_q;
  logic [A_WIDTH-1:0]      rd_addr_q;
  logic [A_WIDTH-1:0]      new_addr_q;
  logic [CW-1:0]           cnt_q;
  logic [LW-1:0]           lat_q;
  logic [KEY_WIDTH-1:0]    entry_key_q;
  logic [VALUE_WIDTH-1:0]  entry_value_q;
  logic [A_WIDTH-1:0]      entry_next_q;
  logic                    entry_next_val_q;
  logic [VALUE_WIDTH-1:0]  old_value_q;

  logic rd_data_valid, key_match, at_limit;

  assign rd_data_valid = (state_q == S_RD_WAIT) && (lat_q == LW'(RAM_LATENCY - 1));
  assign key_match     = (rd_key_i == key_q);
  assign at_limit      = (cnt_q == CW'(MAX_CHAIN_LEN));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision and the result code that goes with entering RESULT.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    res_code_d = res_code_q;
    case (state_q)
      S_IDLE: begin
        if (task_valid_i) begin
          if (task_head_ptr_val_i) begin
            state_d = S_RD_REQ;
          end else if (task_mode_i == MODE_UPDATE_ONLY) begin
            state_d = S_RESULT; res_code_d = RC_NOT_FOUND;
          end else if (!empty_addr_val_i) begin
            state_d = S_RESULT; res_code_d = RC_FULL;
          end else begin
            state_d = S_WR_NEW;
          end
        end
      end
      S_RD_REQ: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (rd_data_valid) begin
          if (key_match) begin
            if (mode_q == MODE_INSERT_ONLY) begin
              state_d = S_RESULT; res_code_d = RC_KEY_EXISTS;
            end else begin
              state_d = S_WR_UPD;
            end
          end else if (rd_next_ptr_val_i) begin
            if (at_limit) begin
              state_d = S_RESULT; res_code_d = RC_CHAIN_LIMIT;
            end else begin
              state_d = S_RD_REQ;
            end
          end else if (mode_q == MODE_UPDATE_ONLY) begin
            state_d = S_RESULT; res_code_d = RC_NOT_FOUND;
          end else if (!empty_addr_val_i) begin
            state_d = S_RESULT; res_code_d = RC_FULL;
          end else begin
            state_d = S_WR_NEW;
          end
        end
      end
      S_WR_NEW:  state_d = S_WR_LINK;
      S_WR_LINK: begin state_d = S_RESULT; res_code_d = RC_OK_NEW; end
      S_WR_UPD:  begin state_d = S_RESULT; res_code_d = RC_OK_UPDATED; end
      S_RESULT:  if (res_ready_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Task latch, chain-walk counters and the entry read from RAM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_code_q       <= '0;
      key_q            <= '0;
      value_q          <= '0;
      mode_q           <= '0;
      bucket_q         <= '0;
      head_val_q       <= 1'b0;
      rd_addr_q        <= '0;
      new_addr_q       <= '0;
      cnt_q            <= '0;
      lat_q            <= '0;
      entry_key_q      <= '0;
      entry_value_q    <= '0;
      entry_next_q     <= '0;
      entry_next_val_q <= 1'b0;
      old_value_q      <= '0;
    end else begin
      res_code_q <= res_code_d;
      case (state_q)
        S_IDLE: begin
          if (task_valid_i) begin
            key_q       <= task_key_i;
            value_q     <= task_value_i;
            mode_q      <= task_mode_i;
            bucket_q    <= task_bucket_i;
            head_val_q  <= task_head_ptr_val_i;
            rd_addr_q   <= task_head_ptr_i;
            new_addr_q  <= empty_addr_i;
            cnt_q       <= '0;
            old_value_q <= '0;
          end
        end
        S_RD_REQ: begin
          cnt_q <= cnt_q + CW'(1);
          lat_q <= '0;
        end
        S_RD_WAIT: begin
          lat_q <= lat_q + LW'(1);
          if (rd_data_valid) begin
            entry_key_q      <= rd_key_i;
            entry_value_q    <= rd_value_i;
            entry_next_q     <= rd_next_ptr_i;
            entry_next_val_q <= rd_next_ptr_val_i;
            if (key_match) begin
              old_value_q <= rd_value_i;
            end else if (rd_next_ptr_val_i) begin
              rd_addr_q <= rd_next_ptr_i;
            end else begin
              new_addr_q <= empty_addr_i;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // RAM, free-list and head-table strobes decoded from the current state.
  always_comb begin
    rd_en_o             = (state_q == S_RD_REQ);
    rd_addr_o           = rd_addr_q;
    wr_en_o             = 1'b0;
    wr_addr_o           = rd_addr_q;
    wr_key_o            = entry_key_q;
    wr_value_o          = entry_value_q;
    wr_next_ptr_o       = entry_next_q;
    wr_next_ptr_val_o   = entry_next_val_q;
    head_wr_en_o        = 1'b0;
    head_wr_addr_o      = bucket_q;
    head_wr_ptr_o       = new_addr_q;
    head_wr_ptr_val_o   = 1'b0;
    empty_addr_rd_ack_o = 1'b0;
    case (state_q)
      S_WR_NEW: begin
        wr_en_o           = 1'b1;
        wr_addr_o         = new_addr_q;
        wr_key_o          = key_q;
        wr_value_o        = value_q;
        wr_next_ptr_o     = '0;
        wr_next_ptr_val_o = 1'b0;
      end
      S_WR_LINK: begin
        empty_addr_rd_ack_o = 1'b1;
        if (head_val_q) begin
          wr_en_o           = 1'b1;
          wr_next_ptr_o     = new_addr_q;
          wr_next_ptr_val_o = 1'b1;
        end else begin
          head_wr_en_o      = 1'b1;
          head_wr_ptr_val_o = 1'b1;
        end
      end
      S_WR_UPD: begin
        wr_en_o    = 1'b1;
        wr_value_o = value_q;
      end
      default: ;
    endcase
  end

  assign task_ready_o    = (state_q == S_IDLE);
  assign res_valid_o     = (state_q == S_RESULT);
  assign res_code_o      = res_code_q;
  assign res_key_o       = key_q;
  assign res_bucket_o    = bucket_q;
  assign res_old_value_o = old_value_q;
  assign res_chain_len_o = cnt_q;

endmodule

// File: tb/tb_data_table_upsert.sv
// Scoreboard bench for data_table_upsert: directed tasks push expected reads,
// writes, head writes and results; a negedge monitor pops and compares.
module tb_data_table_upsert;

  localparam int LAT = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] task_key_i;
  logic [15:0] task_value_i;
  logic [1:0]  task_mode_i;
  logic [7:0]  task_bucket_i, task_head_ptr_i;
  logic        task_head_ptr_val_i, task_valid_i, task_ready_o;
  logic        rd_en_o;
  logic [7:0]  rd_addr_o;
  logic [31:0] rd_key_i;
  logic [15:0] rd_value_i;
  logic [7:0]  rd_next_ptr_i;
  logic        rd_next_ptr_val_i;
  logic        wr_en_o;
  logic [7:0]  wr_addr_o;
  logic [31:0] wr_key_o;
  logic [15:0] wr_value_o;
  logic [7:0]  wr_next_ptr_o;
  logic        wr_next_ptr_val_o;
  logic [7:0]  empty_addr_i;
  logic        empty_addr_val_i, empty_addr_rd_ack_o;
  logic        head_wr_en_o;
  logic [7:0]  head_wr_addr_o, head_wr_ptr_o;
  logic        head_wr_ptr_val_o;
  logic        res_valid_o, res_ready_i;
  logic [2:0]  res_code_o;
  logic [31:0] res_key_o;
  logic [7:0]  res_bucket_o;
  logic [15:0] res_old_value_o;
  logic [1:0]  res_chain_len_o;

  data_table_upsert #(
    .KEY_WIDTH(32), .VALUE_WIDTH(16), .A_WIDTH(8), .BUCKET_WIDTH(8),
    .RAM_LATENCY(LAT), .MAX_CHAIN_LEN(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .task_key_i(task_key_i), .task_value_i(task_value_i), .task_mode_i(task_mode_i),
    .task_bucket_i(task_bucket_i), .task_head_ptr_i(task_head_ptr_i),
    .task_head_ptr_val_i(task_head_ptr_val_i), .task_valid_i(task_valid_i),
    .task_ready_o(task_ready_o),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_key_i(rd_key_i), .rd_value_i(rd_value_i),
    .rd_next_ptr_i(rd_next_ptr_i), .rd_next_ptr_val_i(rd_next_ptr_val_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_key_o(wr_key_o), .wr_value_o(wr_value_o),
    .wr_next_ptr_o(wr_next_ptr_o), .wr_next_ptr_val_o(wr_next_ptr_val_o),
    .empty_addr_i(empty_addr_i), .empty_addr_val_i(empty_addr_val_i),
    .empty_addr_rd_ack_o(empty_addr_rd_ack_o),
    .head_wr_en_o(head_wr_en_o), .head_wr_addr_o(head_wr_addr_o),
    .head_wr_ptr_o(head_wr_ptr_o), .head_wr_ptr_val_o(head_wr_ptr_val_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_code_o(res_code_o),
    .res_key_o(res_key_o), .res_bucket_o(res_bucket_o),
    .res_old_value_o(res_old_value_o), .res_chain_len_o(res_chain_len_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- RAM model: data appears exactly LAT cycles after rd_en_o
  logic [31:0] mem_key  [256];
  logic [15:0] mem_val  [256];
  logic [7:0]  mem_next [256];
  logic        mem_nv   [256];
  logic [7:0]  pipe_addr [LAT];
  logic        pipe_v    [LAT];

  initial for (int i = 0; i < LAT; i++) begin pipe_v[i] = 1'b0; pipe_addr[i] = '0; end

  always @(posedge clk_i) begin
    pipe_v[0]    <= rd_en_o;
    pipe_addr[0] <= rd_addr_o;
    for (int i = 1; i < LAT; i++) begin
      pipe_v[i]    <= pipe_v[i-1];
      pipe_addr[i] <= pipe_addr[i-1];
    end
  end

  assign rd_key_i          = pipe_v[LAT-1] ? mem_key[pipe_addr[LAT-1]]  : 32'hDEAD_BEEF;
  assign rd_value_i        = pipe_v[LAT-1] ? mem_val[pipe_addr[LAT-1]]  : 16'hBAD0;
  assign rd_next_ptr_i     = pipe_v[LAT-1] ? mem_next[pipe_addr[LAT-1]] : 8'hEE;
  assign rd_next_ptr_val_i = pipe_v[LAT-1] ? mem_nv[pipe_addr[LAT-1]]   : 1'b1;

  // ---------------- scoreboard
  typedef struct packed {
    logic [7:0] addr; logic [31:0] key; logic [15:0] val; logic [7:0] np; logic nv;
  } wr_t;
  typedef struct packed {
    logic [2:0] code; logic [31:0] key; logic [7:0] bucket; logic [15:0] old;
    logic [1:0] len; logic [3:0] acks;
  } res_t;
  typedef struct packed { logic [7:0] bucket; logic [7:0] ptr; } head_t;

  logic [7:0] exp_rd_q [$];
  wr_t        exp_wr_q [$];
  head_t      exp_head_q [$];
  res_t       exp_res_q [$];

  int n_cmp = 0;
  int n_err = 0;
  int ack_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void exp_rd(input logic [7:0] a);
    exp_rd_q.push_back(a);
  endfunction
  function automatic void exp_wr(input logic [7:0] a, input logic [31:0] k,
                                 input logic [15:0] v, input logic [7:0] np, input logic nv);
    exp_wr_q.push_back('{addr: a, key: k, val: v, np: np, nv: nv});
  endfunction
  function automatic void exp_res(input logic [2:0] c, input logic [31:0] k, input logic [7:0] b,
                                  input logic [15:0] o, input logic [1:0] l, input logic [3:0] a);
    exp_res_q.push_back('{code: c, key: k, bucket: b, old: o, len: l, acks: a});
  endfunction

  // Monitor: compares every DUT strobe against the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_i === 1'b0) begin
      if (rd_en_o || wr_en_o || head_wr_en_o)
        check("strobe_exclusive", 64'(rd_en_o + wr_en_o + head_wr_en_o), 64'd1);
      if (rd_en_o) begin
        if (exp_rd_q.size() == 0) check("rd_unexpected", 64'(exp_rd_q.size()), 64'd1);
        else check("rd_addr", 64'(rd_addr_o), 64'(exp_rd_q.pop_front()));
      end
      if (wr_en_o) begin
        if (exp_wr_q.size() == 0) check("wr_unexpected", 64'(exp_wr_q.size()), 64'd1);
        else begin
          wr_t w;
          w = exp_wr_q.pop_front();
          check("wr_addr", 64'(wr_addr_o), 64'(w.addr));
          check("wr_key", 64'(wr_key_o), 64'(w.key));
          check("wr_value", 64'(wr_value_o), 64'(w.val));
          check("wr_next", 64'({wr_next_ptr_val_o, wr_next_ptr_o}), 64'({w.nv, w.np}));
        end
      end
      if (head_wr_en_o) begin
        if (exp_head_q.size() == 0) check("head_unexpected", 64'(exp_head_q.size()), 64'd1);
        else begin
          head_t h;
          h = exp_head_q.pop_front();
          check("head_wr", 64'({head_wr_addr_o, head_wr_ptr_o, head_wr_ptr_val_o}),
                64'({h.bucket, h.ptr, 1'b1}));
        end
      end
      if (empty_addr_rd_ack_o) ack_seen++;
      if (res_valid_o && res_ready_i) begin
        if (exp_res_q.size() == 0) check("res_unexpected", 64'(exp_res_q.size()), 64'd1);
        else begin
          res_t r;
          r = exp_res_q.pop_front();
          check("res_code", 64'(res_code_o), 64'(r.code));
          check("res_key", 64'(res_key_o), 64'(r.key));
          check("res_bucket", 64'(res_bucket_o), 64'(r.bucket));
          check("res_old_value", 64'(res_old_value_o), 64'(r.old));
          check("res_chain_len", 64'(res_chain_len_o), 64'(r.len));
          check("ack_count", 64'(ack_seen), 64'(r.acks));
        end
        ack_seen = 0;
      end
    end
  end

  // Drives one task, waits for the result and optionally stalls res_ready_i.
  task automatic run_task(input logic [31:0] key, input logic [15:0] val, input logic [1:0] mode,
                          input logic [7:0] bucket, input logic [7:0] head, input logic hval,
                          input logic [7:0] eaddr, input logic evalid, input int exp_lat,
                          input int hold);
    int cyc;
    logic got;
    logic [63:0] snap;
    @(posedge clk_i); #1;
    task_key_i = key; task_value_i = val; task_mode_i = mode; task_bucket_i = bucket;
    task_head_ptr_i = head; task_head_ptr_val_i = hval;
    empty_addr_i = eaddr; empty_addr_val_i = evalid;
    res_ready_i = (hold == 0);
    task_valid_i = 1'b1;
    @(posedge clk_i); #1;
    task_valid_i = 1'b0;
    if (!hval) empty_addr_i = 8'h55;
    cyc = 0; got = 1'b0;
    while (cyc < 100 && !got) begin
      @(negedge clk_i);
      cyc++;
      got = res_valid_o;
    end
    check("res_timeout", 64'(got), 64'd1);
    check("latency", 64'(cyc), 64'(exp_lat));
    if (hold > 0) begin
      snap = 64'({res_code_o, res_key_o, res_bucket_o, res_old_value_o, res_chain_len_o});
      repeat (hold) begin
        @(negedge clk_i);
        check("hold_stable",
              64'({res_code_o, res_key_o, res_bucket_o, res_old_value_o, res_chain_len_o}), snap);
        check("hold_task_ready", 64'(task_ready_o), 64'd0);
        check("hold_res_valid", 64'(res_valid_o), 64'd1);
      end
      @(posedge clk_i); #1;
      res_ready_i = 1'b1;
    end
    @(posedge clk_i); #1;
    check("back_to_idle", 64'(task_ready_o), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_key[i] = 32'hF000_0000 | 32'(i); mem_val[i] = 16'hFFFF;
      mem_next[i] = 8'h00; mem_nv[i] = 1'b0;
    end
    // chain 0x03 -> 0x04 (tail carries a stale next_ptr that must be preserved)
    mem_key[8'h03] = 32'hAA; mem_val[8'h03] = 16'h1; mem_next[8'h03] = 8'h04; mem_nv[8'h03] = 1'b1;
    mem_key[8'h04] = 32'hBB; mem_val[8'h04] = 16'h9; mem_next[8'h04] = 8'h30; mem_nv[8'h04] = 1'b0;
    // chain of three 0x10 -> 0x11 -> 0x12
    mem_key[8'h10] = 32'h1; mem_next[8'h10] = 8'h11; mem_nv[8'h10] = 1'b1;
    mem_key[8'h11] = 32'h2; mem_next[8'h11] = 8'h12; mem_nv[8'h11] = 1'b1;
    mem_key[8'h12] = 32'h3; mem_next[8'h12] = 8'h00; mem_nv[8'h12] = 1'b0;

    rst_i = 1'b1; task_valid_i = 1'b0; task_key_i = '0; task_value_i = '0; task_mode_i = '0;
    task_bucket_i = '0; task_head_ptr_i = '0; task_head_ptr_val_i = 1'b0;
    empty_addr_i = '0; empty_addr_val_i = 1'b0; res_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_task_ready", 64'(task_ready_o), 64'd1);
    check("rst_strobes", 64'({rd_en_o, wr_en_o, head_wr_en_o, empty_addr_rd_ack_o, res_valid_o}), 64'd0);
    check("rst_res_regs", 64'({res_code_o, res_old_value_o, res_chain_len_o}), 64'd0);
    rst_i = 1'b0;

    // empty bucket upsert; empty_addr_i changes after accept, latched 0x07 must be used
    exp_wr(8'h07, 32'h11, 16'h5, 8'h00, 1'b0);
    exp_head_q.push_back('{bucket: 8'h2A, ptr: 8'h07});
    exp_res(3'd0, 32'h11, 8'h2A, 16'h0, 2'd0, 4'd1);
    run_task(32'h11, 16'h5, 2'd0, 8'h2A, 8'h00, 1'b0, 8'h07, 1'b1, 3, 0);

    // upsert matching the second entry: two reads, value rewritten, next_ptr kept
    exp_rd(8'h03); exp_rd(8'h04);
    exp_wr(8'h04, 32'hBB, 16'hA, 8'h30, 1'b0);
    exp_res(3'd1, 32'hBB, 8'h05, 16'h9, 2'd2, 4'd0);
    run_task(32'hBB, 16'hA, 2'd0, 8'h05, 8'h03, 1'b1, 8'h40, 1'b1, 8, 0);

    // update-only matching the head entry
    exp_rd(8'h03);
    exp_wr(8'h03, 32'hAA, 16'h77, 8'h04, 1'b1);
    exp_res(3'd1, 32'hAA, 8'h05, 16'h1, 2'd1, 4'd0);
    run_task(32'hAA, 16'h77, 2'd2, 8'h05, 8'h03, 1'b1, 8'h40, 1'b1, 5, 0);

    // insert-only on an existing key, result stalled 5 cycles
    exp_rd(8'h03); exp_rd(8'h04);
    exp_res(3'd3, 32'hBB, 8'h05, 16'h9, 2'd2, 4'd0);
    run_task(32'hBB, 16'h2, 2'd1, 8'h05, 8'h03, 1'b1, 8'h40, 1'b1, 7, 5);

    // update-only on an absent key
    exp_rd(8'h03); exp_rd(8'h04);
    exp_res(3'd4, 32'hCC, 8'h05, 16'h0, 2'd2, 4'd0);
    run_task(32'hCC, 16'h3, 2'd2, 8'h05, 8'h03, 1'b1, 8'h20, 1'b1, 7, 0);

    // append at tail with mode 3 (upsert): new entry first, then the link
    exp_rd(8'h03); exp_rd(8'h04);
    exp_wr(8'h20, 32'hCC, 16'h3, 8'h00, 1'b0);
    exp_wr(8'h04, 32'hBB, 16'h9, 8'h20, 1'b1);
    exp_res(3'd0, 32'hCC, 8'h05, 16'h0, 2'd2, 4'd1);
    run_task(32'hCC, 16'h3, 2'd3, 8'h05, 8'h03, 1'b1, 8'h20, 1'b1, 9, 0);

    // tail reached with no free entry
    exp_rd(8'h03); exp_rd(8'h04);
    exp_res(3'd2, 32'hCC, 8'h05, 16'h0, 2'd2, 4'd0);
    run_task(32'hCC, 16'h3, 2'd0, 8'h05, 8'h03, 1'b1, 8'h20, 1'b0, 7, 0);

    // empty bucket: update-only and no free entry
    exp_res(3'd4, 32'h21, 8'h09, 16'h0, 2'd0, 4'd0);
    run_task(32'h21, 16'h1, 2'd2, 8'h09, 8'h00, 1'b0, 8'h08, 1'b1, 1, 0);
    exp_res(3'd2, 32'h22, 8'h09, 16'h0, 2'd0, 4'd0);
    run_task(32'h22, 16'h1, 2'd1, 8'h09, 8'h00, 1'b0, 8'h08, 1'b0, 1, 0);

    // chain of three with no match: stops after two reads
    exp_rd(8'h10); exp_rd(8'h11);
    exp_res(3'd5, 32'h9, 8'h0C, 16'h0, 2'd2, 4'd0);
    run_task(32'h9, 16'h4, 2'd0, 8'h0C, 8'h10, 1'b1, 8'h21, 1'b1, 7, 0);

    // reset while waiting for read data
    exp_rd(8'h03);
    @(posedge clk_i); #1;
    task_key_i = 32'hBB; task_value_i = 16'h6; task_mode_i = 2'd0; task_bucket_i = 8'h05;
    task_head_ptr_i = 8'h03; task_head_ptr_val_i = 1'b1; empty_addr_val_i = 1'b1;
    task_valid_i = 1'b1;
    @(posedge clk_i); #1;
    task_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    #1;
    check("midrst_strobes", 64'({rd_en_o, wr_en_o, head_wr_en_o, empty_addr_rd_ack_o, res_valid_o}), 64'd0);
    check("midrst_idle", 64'(task_ready_o), 64'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (6) begin
      @(posedge clk_i); #1;
      check("postrst_quiet", 64'({rd_en_o, wr_en_o, head_wr_en_o, empty_addr_rd_ack_o, res_valid_o}), 64'd0);
    end

    // recovery after reset
    exp_wr(8'h33, 32'h44, 16'h8, 8'h00, 1'b0);
    exp_head_q.push_back('{bucket: 8'h01, ptr: 8'h33});
    exp_res(3'd0, 32'h44, 8'h01, 16'h0, 2'd0, 4'd1);
    run_task(32'h44, 16'h8, 2'd0, 8'h01, 8'h00, 1'b0, 8'h33, 1'b1, 3, 0);

    repeat (4) @(posedge clk_i);
    check("left_rd", 64'(exp_rd_q.size()), 64'd0);
    check("left_wr", 64'(exp_wr_q.size()), 64'd0);
    check("left_head", 64'(exp_head_q.size()), 64'd0);
    check("left_res", 64'(exp_res_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_table_upsert.md
Name: data_table_upsert

Overview:
- Parametrised successor to the hash-table insert engine.
- Walks a bucket chain in data RAM and performs one of three modes per task: upsert, insert-only or update-only.
- Enforces a programmable maximum chain length and returns the old value plus the walked chain length.
- Sits between the command dispatcher and the shared data RAM, empty-pointer storage and head table.

Parameters:
- KEY_WIDTH, 32, key width in bits
- VALUE_WIDTH, 16, value width in bits
- A_WIDTH, 8, data-RAM address width
- BUCKET_WIDTH, 8, head-table address width
- RAM_LATENCY, 2, data-RAM read latency in cycles (>=1)
- MAX_CHAIN_LEN, 16, maximum entries read per task (>=1); CW=$clog2(MAX_CHAIN_LEN+1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- task_key_i  in  KEY_WIDTH  command key
- task_value_i  in  VALUE_WIDTH  command value
- task_mode_i  in  2  0=UPSERT, 1=INSERT_ONLY, 2=UPDATE_ONLY, 3=treated as UPSERT
- task_bucket_i  in  BUCKET_WIDTH  bucket index
- task_head_ptr_i  in  A_WIDTH  chain head address
- task_head_ptr_val_i  in  1  head pointer valid
- task_valid_i  in  1  / task_ready_o  out  1  task handshake
- rd_en_o  out  1  / rd_addr_o  out  A_WIDTH  RAM read request
- rd_key_i, rd_value_i, rd_next_ptr_i, rd_next_ptr_val_i  in  KEY/VALUE/A_WIDTH/1  RAM read data
- wr_en_o  out  1  / wr_addr_o  out  A_WIDTH  RAM write strobe and address
- wr_key_o, wr_value_o, wr_next_ptr_o, wr_next_ptr_val_o  out  KEY/VALUE/A_WIDTH/1  RAM write data
- empty_addr_i  in  A_WIDTH  / empty_addr_val_i  in  1  free-list head
- empty_addr_rd_ack_o  out  1  pop free-list head
- head_wr_en_o  out  1  / head_wr_addr_o  out  BUCKET_WIDTH  / head_wr_ptr_o  out  A_WIDTH  / head_wr_ptr_val_o  out  1  head-table write
- res_valid_o  out  1  / res_ready_i  in  1  result handshake
- res_code_o  out  3  0=OK_NEW, 1=OK_UPDATED, 2=FAIL_FULL, 3=FAIL_KEY_EXISTS, 4=FAIL_NOT_FOUND, 5=FAIL_CHAIN_LIMIT
- res_key_o  out  KEY_WIDTH  / res_bucket_o  out  BUCKET_WIDTH  echo of the locked task
- res_old_value_o  out  VALUE_WIDTH  previous value on a key match, else 0
- res_chain_len_o  out  CW  number of entries read

Behaviour:
- Reset: state IDLE. All strobes, res_valid_o, counters and latched registers are 0. task_ready_o is 1 after reset.
- States: IDLE, RD_REQ, RD_WAIT, WR_NEW, WR_LINK, WR_UPD, RESULT. Only one task is in flight; task_ready_o = (state==IDLE).
- IDLE, on accept: latch the task and clear cnt.
  - No head, mode UPDATE_ONLY -> RESULT(NOT_FOUND).
  - No head, !empty_addr_val_i -> RESULT(FULL).
  - No head, otherwise: latch new_addr = empty_addr_i -> WR_NEW.
  - Head valid: rd_addr <= head_ptr -> RD_REQ.
- RD_REQ: rd_en_o=1 for exactly one cycle at rd_addr; cnt++ -> RD_WAIT.
- RD_WAIT: read data is valid exactly RAM_LATENCY cycles after the rd_en_o cycle. On valid, latch the entry, then:
  - Key match, INSERT_ONLY -> RESULT(KEY_EXISTS), old value reported.
  - Key match, otherwise -> WR_UPD.
  - No match, next_ptr_val=1, cnt==MAX_CHAIN_LEN -> RESULT(CHAIN_LIMIT).
  - No match, next_ptr_val=1, otherwise: rd_addr <= next_ptr -> RD_REQ.
  - Tail reached, UPDATE_ONLY -> NOT_FOUND.
  - Tail reached, !empty_addr_val_i -> FULL.
  - Tail reached, otherwise: latch new_addr -> WR_NEW.
- WR_NEW: one wr_en_o at new_addr with {task key, task value, next_ptr 0, next_ptr_val 0} -> WR_LINK.
- WR_LINK: empty_addr_rd_ack_o=1 for exactly this cycle.
  - No-head case: head_wr_en_o=1 with bucket, new_addr, val=1.
  - Otherwise: wr_en_o at rd_addr with the latched entry, next_ptr=new_addr, next_ptr_val=1.
  - -> RESULT(OK_NEW).
- WR_UPD: one wr_en_o at rd_addr with the latched key and next_ptr and the task value -> RESULT(OK_UPDATED).
- RESULT: res_* are stable while res_valid_o=1. Leave to IDLE on res_valid_o && res_ready_i; the next task can be accepted in the following cycle.
- Ordering: the new entry is always written before any link to it, so the chain never references unwritten data.
- new_addr is used from the latched copy even if empty_addr_i changes before WR_LINK.
- wr_en_o, head_wr_en_o and rd_en_o are never asserted in the same cycle.
- Latency, no-head insert: accept at edge 0, res_valid_o at cycle 3.
- Latency, chain walk: each entry read costs 1+RAM_LATENCY cycles.
- Reset mid-operation: immediate return to IDLE with no ack and no further writes. An orphaned WR_NEW entry is acceptable; the chain stays consistent.

Test Plan:
- RAM_LATENCY=2, empty head, UPSERT key 0x11 value 0x5, empty_addr 0x07 -> WR @0x07 {0x11,0x5,0,0}, then head write bucket->0x07, ack 1 cycle, OK_NEW, chain_len 0, valid at cycle 3.
- Chain 0x03->0x04, key at 0x04 old value 0x9, UPSERT value 0xA -> two reads, WR @0x04 value 0xA with next_ptr preserved, OK_UPDATED, old value 0x9, chain_len 2.
- Same chain, INSERT_ONLY matching key -> no write, no ack, KEY_EXISTS; UPDATE_ONLY absent key -> NOT_FOUND, no write.
- Tail 0x04, empty_addr 0x20 -> WR @0x20 then WR @0x04 next_ptr 0x20 val 1, ack exactly once; empty_addr_val_i=0 instead -> FULL, no write.
- MAX_CHAIN_LEN=2, chain of 3 with no match -> exactly 2 reads, CHAIN_LIMIT, chain_len 2.
- res_ready_i held low 5 cycles -> outputs stable, task_ready_o=0; rst_i in RD_WAIT -> all strobes 0 next cycle, IDLE.
